lm_sm_sequencer: RTL and testbench

//  Decode-stage micro-sequencer between the IF/ID register and the control decoder / RR stage.

---
 rtl/lm_sm_sequencer.sv | 129 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// Decode-stage micro-sequencer: passes ordinary instructions through and
// expands LM/SM into one LW/SW micro-op per set mask bit, holding fetch meanwhile.
module lm_sm_sequencer #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned MASK_W  = 8,
   parameter logic [3:0]  OP_LM   = 4'b0110,
   parameter logic [3:0]  OP_SM   = 4'b0111
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               stall,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [INSTR_W-1:0] in_pc,
   output logic               in_ready,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [INSTR_W-1:0] out_pc,
   output logic               out_last
);

   localparam int unsigned OFF_W = 6;
   localparam int unsigned REG_W = 3;
   localparam logic [3:0]  OP_LW = 4'b0100;
   localparam logic [3:0]  OP_SW = 4'b0101;

   typedef enum logic {IDLE, SEQ} state_t;

   state_t             state;
   logic [MASK_W-1:0]  pend;
   logic [MASK_W-1:0]  orig_mask;
   logic [REG_W-1:0]   ra;
   logic               is_lm;
   logic [INSTR_W-1:0] pc_q;

   logic [3:0]         in_op;
   logic               in_lmsm;
   logic               accept;
   logic [MASK_W-1:0]  src_mask, src_orig, eff, rest;
   logic [REG_W-1:0]   src_ra, pop_idx;
   logic               src_lm;
   logic [OFF_W-1:0]   off;
   logic [INSTR_W-1:0] micro;
   logic               unused_bit;

   assign unused_bit = in_instr[8];
   assign in_op      = in_instr[INSTR_W-1 -: 4];
   assign in_lmsm    = (in_op == OP_LM) || (in_op == OP_SM);
   assign in_ready   = (state == IDLE) && !stall && !flush;
   assign accept     = in_valid && in_ready;

   // Pick the next register to pop: lowest set bit, with LM's base register deferred to last.
   always_comb begin
      src_mask = (state == SEQ) ? pend      : in_instr[MASK_W-1:0];
      src_orig = (state == SEQ) ? orig_mask : in_instr[MASK_W-1:0];
      src_ra   = (state == SEQ) ? ra        : in_instr[11:9];
      src_lm   = (state == SEQ) ? is_lm     : (in_op == OP_LM);
      eff      = src_mask;
      if (src_lm) eff[src_ra] = 1'b0;
      if (eff == '0) eff = src_mask;
      pop_idx = '0;
      for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
         if (eff[i]) pop_idx = REG_W'(i);
      end
      rest = src_mask;
      rest[pop_idx] = 1'b0;
      off = '0;
      for (int i = 0; i < int'(MASK_W); i++) begin
         if (src_orig[i] && (i < int'(pop_idx))) off = off + OFF_W'(1);
      end
      micro = {(src_lm ? OP_LW : OP_SW), pop_idx, src_ra, off};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= '0;
         orig_mask <= '0;
         ra        <= '0;
         is_lm     <= 1'b0;
         pc_q      <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
         out_last  <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         pend      <= '0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         case (state)
            IDLE: begin
               if (!accept) begin
                  out_valid <= 1'b0;
               end else if (!in_lmsm) begin
                  out_valid <= 1'b1;
                  out_instr <= in_instr;
                  out_pc    <= in_pc;
                  out_last  <= 1'b1;
               end else if (in_instr[MASK_W-1:0] == '0) begin
                  out_valid <= 1'b0;
               end else begin
                  orig_mask <= in_instr[MASK_W-1:0];
                  ra        <= in_instr[11:9];
                  is_lm     <= (in_op == OP_LM);
                  pc_q      <= in_pc;
                  pend      <= rest;
                  out_valid <= 1'b1;
                  out_instr <= micro;
                  out_pc    <= in_pc;
                  out_last  <= (rest == '0);
                  state     <= (rest == '0) ? IDLE : SEQ;
               end
            end
            SEQ: begin
               pend      <= rest;
               out_valid <= 1'b1;
               out_instr <= micro;
               out_pc    <= pc_q;
               out_last  <= (rest == '0);
               if (rest == '0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed cases plus randomized
// instructions with random stalls, checked against an expansion model.
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        reset, flush, stall, in_valid;
   logic [15:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_last;
   logic [15:0] out_instr, out_pc;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   lm_sm_sequencer dut (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
      .out_pc(out_pc), .out_last(out_last)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected micro-op list: memory slots are ranked by register index; LM defers its base register.
   function automatic void build(input logic [15:0] ins);
      logic [3:0] op;
      logic [2:0] rbase;
      logic [7:0] m;
      logic       lm;
      exp_q.delete();
      op    = ins[15:12];
      rbase = ins[11:9];
      m     = ins[7:0];
      lm    = (op == 4'b0110);
      if (op != 4'b0110 && op != 4'b0111) begin
         exp_q.push_back(ins);
         return;
      end
      for (int r = 0; r < 8; r++) begin
         if (m[r] && !(lm && r == int'(rbase))) exp_q.push_back(fmt(lm, r, rbase, m));
      end
      if (lm && m[rbase]) exp_q.push_back(fmt(lm, int'(rbase), rbase, m));
   endfunction

   function automatic logic [15:0] fmt(input logic lm, input int r, input logic [2:0] rb, input logic [7:0] m);
      int rank = 0;
      for (int j = 0; j < r; j++) if (m[j]) rank++;
      return {(lm ? 4'b0100 : 4'b0101), 3'(r), rb, 6'(rank)};
   endfunction

   // Issue one instruction and check its full emission; stalls optionally inserted.
   task automatic run(input logic [15:0] ins, input logic [15:0] pc, input int spct,
                      input int stall_at, input int stall_len);
      int n, nst;
      chk("ready_before_issue", 16'(in_ready), 16'd1);
      in_valid = 1'b1; in_instr = ins; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 1'b0; in_instr = 16'($urandom); in_pc = 16'($urandom);
      n = exp_q.size();
      if (n == 0) begin
         chk("empty_valid", 16'(out_valid), 16'd0);
         chk("empty_ready", 16'(in_ready), 16'd1);
         return;
      end
      for (int i = 0; i < n; i++) begin
         chk("op_valid", 16'(out_valid), 16'd1);
         chk("op_instr", out_instr, exp_q[i]);
         chk("op_pc", out_pc, pc);
         chk("op_last", 16'(out_last), 16'(i == n - 1));
         chk("op_ready", 16'(in_ready), 16'(i == n - 1));
         nst = (i == stall_at) ? stall_len : (int'($urandom_range(99)) < spct ? 1 : 0);
         for (int s = 0; s < nst; s++) begin
            stall = 1'b1; #1;
            chk("stall_ready", 16'(in_ready), 16'd0);
            @(posedge clk); #1;
            chk("stall_valid", 16'(out_valid), 16'd1);
            chk("stall_instr", out_instr, exp_q[i]);
            chk("stall_last", 16'(out_last), 16'(i == n - 1));
         end
         stall = 1'b0;
         @(posedge clk); #1;
      end
      chk("after_valid", 16'(out_valid), 16'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] ins;
      reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      in_instr = '0; in_pc = '0;

      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_instr", out_instr, 16'h0000);
      chk("rst_pc", out_pc, 16'h0000);
      chk("rst_last", 16'(out_last), 16'd0);
      reset = 1'b0; #1;
      chk("rst_ready", 16'(in_ready), 16'd1);

      // pass-through ADD
      exp_q = '{16'h1050};
      run(16'h1050, 16'h0020, 0, -1, 0);

      // LM with base register in mask
      exp_q = '{16'h4080, 16'h4A82, 16'h4E83, 16'h4481};
      run(16'h64A5, 16'h0030, 0, -1, 0);

      // SM with a two-cycle stall after the first op
      exp_q = '{16'h5040, 16'h5241};
      run(16'h7203, 16'h0034, 0, 0, 2);

      // flush on the second micro-op
      in_valid = 1'b1; in_instr = 16'h64A5; in_pc = 16'h0040;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("fl_first", out_instr, 16'h4080);
      @(posedge clk); #1;
      chk("fl_second", out_instr, 16'h4A82);
      flush = 1'b1; #1;
      chk("fl_ready_during", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
      flush = 1'b0; #1;
      chk("fl_valid", 16'(out_valid), 16'd0);
      chk("fl_ready", 16'(in_ready), 16'd1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("fl_quiet", 16'(out_valid), 16'd0);
      end

      // flush drops a same-cycle instruction
      in_valid = 1'b1; in_instr = 16'h1050; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_drop", 16'(out_valid), 16'd0);

      // empty LM then ADD on the next cycle
      in_valid = 1'b1; in_instr = 16'h6000; in_pc = 16'h0050;
      @(posedge clk); #1;
      chk("m0_valid", 16'(out_valid), 16'd0);
      chk("m0_ready", 16'(in_ready), 16'd1);
      in_instr = 16'h1050; in_pc = 16'h0060;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("m0_add_valid", 16'(out_valid), 16'd1);
      chk("m0_add_instr", out_instr, 16'h1050);
      chk("m0_add_pc", out_pc, 16'h0060);
      chk("m0_add_last", 16'(out_last), 16'd1);
      @(posedge clk); #1;

      // randomized instructions with random stalls
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(3))
            0: op = 4'b0110;
            1: op = 4'b0111;
            default: begin
               op = 4'($urandom_range(15));
               if (op == 4'b0110 || op == 4'b0111) op = 4'b0000;
            end
         endcase
         ins = {op, 12'($urandom)};
         case ($urandom_range(7))
            0: ins[7:0] = 8'h00;
            1: ins[7:0] = 8'hFF;
            default: ;
         endcase
         build(ins);
         run(ins, 16'($urandom), 25, -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
